global_static_tracker: RTL and testbench
========================================

// Module: global_static_tracker
// PURPOSE
//  Next-generation global static unit for the Viterbi core. Selects the minimum-energy
//  survivor each block and shifts its B_LEN symbols into a SH_DEPTH-deep decided history.
//  Convolves that history with a programmable slice of the estimated channel and adds
//  rse_vals to give per-branch static offsets. Adds a valid pipeline, flush, prime
//  tracking and saturation over the previous generation. Sits between the state-update
//  array and the branch-metric units.
// PARAMETERS
//  B_WIDTH    8   signed branch/static value width; energies are 2*B_WIDTH unsigned
//  B_LEN      2   symbols decided per block (>=1, <=SH_DEPTH)
//  N_S        7   survivor state count (>=2)
//  SH_DEPTH   18  decided-history depth in symbols
//  EST_DEPTH  30  estimated-channel taps
//  EST_WIDTH  8   signed channel tap width
//  CH_OFFSET  10  first channel tap applied to history; CH_OFFSET+SH_DEPTH+B_LEN-1 <= EST_DEPTH
//  SHIFT      1   arithmetic right shift applied to convolution sum
// PORTS
//  clk                     in   1                     clock
//  rst                     in   1                     sync active-high reset
//  flush                   in   1                     clear history/pipeline, keep channel
//  in_valid                in   1                     state_energies/histories/rse_vals valid
//  state_energies[N_S]     in   2*B_WIDTH             survivor energies, unsigned
//  state_histories[N_S][B_LEN] in 2 signed           survivor symbols, [b]=0 newest
//  est_channel[EST_DEPTH]  in   EST_WIDTH signed      quasi-static channel taps
//  rse_vals[B_LEN]         in   B_WIDTH signed        residual-error terms, sampled with in_valid
//  out_valid               out  1                     outputs below valid
//  decided_symbols[B_LEN]  out  2 signed              hist[B_LEN-1:0]
//  precomputed_static_val[B_LEN] out B_WIDTH signed   sat(static_val + rse)
//  global_static_energy    out  2*B_WIDTH             energy of selected survivor
//  best_state_idx          out  $clog2(N_S)           index of selected survivor
//  history_primed          out  1                     history fully populated since reset/flush
// BEHAVIOUR
//  - Reset (rst=1 at posedge): hist, all outputs, prime counter, pipeline valids = 0.
//  - Stage S0 (in_valid at edge N): min over state_energies, tie -> lowest index;
//    register best idx, energy, histories, rse_vals; v1<=1.
//  - Stage S1 (edge N+1, v1): hist[k+B_LEN]<=hist[k] for k<SH_DEPTH-B_LEN (oldest
//    B_LEN dropped); hist[b]<=best_hist[b]; energy/idx/rse forwarded; v2<=1.
//  - Stage S2 (edge N+2, v2): static_val[j] = sum_{k<SH_DEPTH} hist[k]*
//    est_channel[CH_OFFSET+j+k], full precision, >>>SHIFT, then add rse[j]; result
//    saturates to [-2^(B_WIDTH-1), 2^(B_WIDTH-1)-1]. out_valid<=1 one cycle.
//  - Latency in_valid->out_valid = 3 cycles; back-to-back in_valid every cycle accepted;
//    gaps propagate (out_valid low, outputs hold last value).
//  - Symbol codes: +1/-1 as 2-bit signed; 0 treated as 0 (zero contribution).
//  - Prime counter: +1 per S1 update, saturates at ceil(SH_DEPTH/B_LEN);
//    history_primed=1 at saturation, registered alongside out_valid.
//  - flush: same clear as rst except est_channel not sampled anyway; in_valid with flush
//    in same cycle is dropped; in-flight v1/v2 beats discarded.
//  - rst/flush mid-stream: no out_valid for discarded beats; next accepted beat
//    behaves as first beat after reset.
//  - est_channel sampled combinationally in S2; changes apply to next out_valid.
// CONFIGURATION
//  GST_ENERGY_ACC_EN defined: extra out port acc_energy [2*B_WIDTH+8], += energy each
//    out_valid, saturates at all-ones, cleared by rst/flush.
//  Undefined: port and accumulator absent; all other behaviour identical.
// TESTING (B_LEN=2, SH_DEPTH=4, N_S=3, CH_OFFSET=0, SHIFT=0, taps 1..EST_DEPTH)
//  - Energies {5,3,9}, hist s1={+1,-1} -> 3 cycles later best_state_idx=1,
//    energy=3, decided_symbols={+1,-1}, out_valid one cycle.
//  - Tie energies {4,4,4} -> best_state_idx=0.
//  - Two beats s1 {+1,+1} then {-1,-1} -> hist={-1,-1,+1,+1}; static_val[0]=
//    -1-2+3+4=4, rse=0 -> 4; history_primed=1 on second out_valid.
//  - Taps=127, all +1 history, rse=100 -> precomputed_static_val saturates to 127.
//  - flush in cycle after in_valid -> no out_valid, hist=0, history_primed=0.
//  - Continuous in_valid 8 beats -> 8 consecutive out_valid, first at cycle 3.

Source files
------------

// File: rtl/global_static_tracker_if.sv
// Survivor-in / static-offset-out bundle between the state-update array and the branch-metric units.
// Source side (master) drives the beat fields; the tracker (slave) drives the result fields.
interface global_static_tracker_if #(
  parameter int B_WIDTH = 8,
  parameter int B_LEN   = 2,
  parameter int N_S     = 7
);
  localparam int IDX_W = (N_S > 1) ? $clog2(N_S) : 1;

  logic                                  in_valid;
  logic [N_S-1:0][2*B_WIDTH-1:0]         state_energies;
  logic [N_S-1:0][B_LEN-1:0][1:0]        state_histories;
  logic [B_LEN-1:0][B_WIDTH-1:0]         rse_vals;

  logic                                  out_valid;
  logic [B_LEN-1:0][1:0]                 decided_symbols;
  logic [B_LEN-1:0][B_WIDTH-1:0]         precomputed_static_val;
  logic [2*B_WIDTH-1:0]                  global_static_energy;
  logic [IDX_W-1:0]                      best_state_idx;
  logic                                  history_primed;

  modport master (
    output in_valid, state_energies, state_histories, rse_vals,
    input  out_valid, decided_symbols, precomputed_static_val,
           global_static_energy, best_state_idx, history_primed
  );

  modport slave (
    input  in_valid, state_energies, state_histories, rse_vals,
    output out_valid, decided_symbols, precomputed_static_val,
           global_static_energy, best_state_idx, history_primed
  );
endinterface

// File: rtl/global_static_tracker.sv
// Min-energy survivor select -> decided-history shift -> channel convolution + rse (saturated); 3-cycle latency,
// no backpressure (a beat every cycle is accepted). Define GST_ENERGY_ACC_EN to add the acc_energy_o accumulator.
module global_static_tracker #(
  parameter int B_WIDTH   = 8,
  parameter int B_LEN     = 2,
  parameter int N_S       = 7,
  parameter int SH_DEPTH  = 18,
  parameter int EST_DEPTH = 30,
  parameter int EST_WIDTH = 8,
  parameter int CH_OFFSET = 10,
  parameter int SHIFT     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [EST_DEPTH-1:0][EST_WIDTH-1:0]   est_channel_i,
  global_static_tracker_if.slave                bus
`ifdef GST_ENERGY_ACC_EN
  ,
  output logic [2*B_WIDTH+8-1:0]                acc_energy_o
`endif
);

  localparam int EW        = 2 * B_WIDTH;
  localparam int IDX_W     = (N_S > 1) ? $clog2(N_S) : 1;
  localparam int PRIME_MAX = (SH_DEPTH + B_LEN - 1) / B_LEN;
  localparam int CNT_W     = $clog2(PRIME_MAX + 1);
  localparam int PROD_W    = EST_WIDTH + 2;
  localparam int SUM_W     = PROD_W + $clog2(SH_DEPTH) + 1;
  localparam int RES_W     = ((SUM_W > B_WIDTH) ? SUM_W : B_WIDTH) + 1;

  localparam logic signed [RES_W-1:0] SAT_HI = RES_W'(2 ** (B_WIDTH - 1) - 1);
  localparam logic signed [RES_W-1:0] SAT_LO = ~SAT_HI;

  typedef logic [B_LEN-1:0][1:0]         sym_vec_t;
  typedef logic [B_LEN-1:0][B_WIDTH-1:0] val_vec_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [EW-1:0]    energy;
    val_vec_t         rse;
  } meta_t;

  logic                     v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
  meta_t                    s1_q, s1_d, s2_q, s2_d;
  sym_vec_t                 best_hist_q, best_hist_d;
  logic [SH_DEPTH-1:0][1:0] hist_q, hist_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     primed_q, primed_d;
  sym_vec_t                 dec_q, dec_d;
  val_vec_t                 stat_q, stat_d;
  logic [EW-1:0]            energy_q, energy_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  logic [IDX_W-1:0]         min_idx;
  logic [EW-1:0]            min_e;
  val_vec_t                 stat_calc;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;
  logic signed [RES_W-1:0]  res;

  // Strict less-than keeps the lowest index on equal energies.
  always_comb begin
    min_idx = '0;
    min_e   = bus.state_energies[0];
    for (int s = 1; s < N_S; s++) begin
      if (bus.state_energies[s] < min_e) begin
        min_e   = bus.state_energies[s];
        min_idx = IDX_W'(s);
      end
    end
  end

  // History taps line up with est_channel starting at CH_OFFSET, offset by branch j.
  always_comb begin
    stat_calc = '0;
    prod      = '0;
    sum       = '0;
    res       = '0;
    for (int j = 0; j < B_LEN; j++) begin
      sum = '0;
      for (int k = 0; k < SH_DEPTH; k++) begin
        prod = PROD_W'($signed(hist_q[k])) *
               PROD_W'($signed(est_channel_i[CH_OFFSET + j + k]));
        sum  = sum + SUM_W'(prod);
      end
      res = RES_W'(sum >>> SHIFT) + RES_W'($signed(s2_q.rse[j]));
      if (res > SAT_HI) begin
        stat_calc[j] = SAT_HI[B_WIDTH-1:0];
      end else if (res < SAT_LO) begin
        stat_calc[j] = SAT_LO[B_WIDTH-1:0];
      end else begin
        stat_calc[j] = res[B_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    v1_d        = bus.in_valid;
    s1_d        = s1_q;
    best_hist_d = best_hist_q;
    v2_d        = v1_q;
    s2_d        = s2_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    ov_d        = v2_q;
    dec_d       = dec_q;
    stat_d      = stat_q;
    energy_d    = energy_q;
    idx_d       = idx_q;
    primed_d    = primed_q;

    if (bus.in_valid) begin
      s1_d.idx    = min_idx;
      s1_d.energy = min_e;
      s1_d.rse    = bus.rse_vals;
      best_hist_d = bus.state_histories[min_idx];
    end

    if (v1_q) begin
      s2_d = s1_q;
      for (int k = SH_DEPTH - 1; k >= B_LEN; k--) begin
        hist_d[k] = hist_q[k - B_LEN];
      end
      for (int b = 0; b < B_LEN; b++) begin
        hist_d[b] = best_hist_q[b];
      end
      if (cnt_q != CNT_W'(PRIME_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Outputs only move on a valid beat; gaps leave the last result visible.
    if (v2_q) begin
      dec_d    = hist_q[B_LEN-1:0];
      stat_d   = stat_calc;
      energy_d = s2_q.energy;
      idx_d    = s2_q.idx;
      primed_d = (cnt_q == CNT_W'(PRIME_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      ov_q        <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      best_hist_q <= '0;
      hist_q      <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      dec_q       <= '0;
      stat_q      <= '0;
      energy_q    <= '0;
      idx_q       <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      ov_q        <= ov_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      best_hist_q <= best_hist_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      dec_q       <= dec_d;
      stat_q      <= stat_d;
      energy_q    <= energy_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.out_valid              = ov_q;
  assign bus.decided_symbols        = dec_q;
  assign bus.precomputed_static_val = stat_q;
  assign bus.global_static_energy   = energy_q;
  assign bus.best_state_idx         = idx_q;
  assign bus.history_primed         = primed_q;

`ifdef GST_ENERGY_ACC_EN
  localparam int AW = EW + 8;

  logic [AW-1:0] acc_q, acc_d;
  logic [AW:0]   acc_sum;

  always_comb begin
    acc_d   = acc_q;
    acc_sum = {1'b0, acc_q} + (AW + 1)'(s2_q.energy);
    if (v2_q) begin
      acc_d = acc_sum[AW] ? {AW{1'b1}} : acc_sum[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_energy_o = acc_q;
`endif

endmodule

// File: tb/tb_global_static_tracker.sv
// Directed scoreboard bench for global_static_tracker (B_LEN=2, SH_DEPTH=4, N_S=3, CH_OFFSET=0, SHIFT=0).
module tb_global_static_tracker;

  localparam int BW = 8;
  localparam int BL = 2;
  localparam int NS = 3;
  localparam int SD = 4;
  localparam int ED = 5;
  localparam int EWD = 8;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] M = 2'b11;

  typedef struct {
    int       idx;
    int       energy;
    logic [3:0] dec;
    int       s0;
    int       s1;
    int       primed;
    int       cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [ED-1:0][EWD-1:0] est;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

`ifdef GST_ENERGY_ACC_EN
  logic [2*BW+8-1:0] acc;
`endif

  global_static_tracker_if #(.B_WIDTH(BW), .B_LEN(BL), .N_S(NS)) bus ();

  global_static_tracker #(
    .B_WIDTH(BW), .B_LEN(BL), .N_S(NS), .SH_DEPTH(SD),
    .EST_DEPTH(ED), .EST_WIDTH(EWD), .CH_OFFSET(0), .SHIFT(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .est_channel_i(est),
    .bus          (bus)
`ifdef GST_ENERGY_ACC_EN
    ,
    .acc_energy_o (acc)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per out_valid cycle.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("latency_cycle", cyc, x.cyc);
        chk("best_state_idx", int'(bus.best_state_idx), x.idx);
        chk("global_static_energy", int'(bus.global_static_energy), x.energy);
        chk("decided_symbols", int'({bus.decided_symbols[1], bus.decided_symbols[0]}), int'(x.dec));
        chk("static_val0", int'($signed(bus.precomputed_static_val[0])), x.s0);
        chk("static_val1", int'($signed(bus.precomputed_static_val[1])), x.s1);
        chk("history_primed", int'(bus.history_primed), x.primed);
      end
    end
  end

  task automatic beat(input int e0, e1, e2, input logic [3:0] h0, h1, h2,
                      input int r0, r1, input logic fl, input bit expect_out,
                      input int x_idx, x_e, input logic [3:0] x_dec,
                      input int x_s0, x_s1, x_pr);
    exp_t x;
    @(negedge clk);
    bus.in_valid           = 1'b1;
    flush                  = fl;
    bus.state_energies[0]  = 16'(e0);
    bus.state_energies[1]  = 16'(e1);
    bus.state_energies[2]  = 16'(e2);
    bus.state_histories[0] = h0;
    bus.state_histories[1] = h1;
    bus.state_histories[2] = h2;
    bus.rse_vals[0]        = 8'(r0);
    bus.rse_vals[1]        = 8'(r1);
    if (expect_out) begin
      x.idx = x_idx; x.energy = x_e; x.dec = x_dec;
      x.s0 = x_s0; x.s1 = x_s1; x.primed = x_pr; x.cyc = cyc + 3;
      q.push_back(x);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(negedge clk);
  endtask

  task automatic set_taps(input int ramp, input int val);
    for (int i = 0; i < ED; i++) est[i] = ramp ? 8'(i + 1) : 8'(val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bus.in_valid        = 1'b0;
    bus.state_energies  = '0;
    bus.state_histories = '0;
    bus.rse_vals        = '0;
    set_taps(1, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_primed", int'(bus.history_primed), 0);
    chk("reset_idx", int'(bus.best_state_idx), 0);
    chk("reset_energy", int'(bus.global_static_energy), 0);
    chk("reset_static0", int'(bus.precomputed_static_val[0]), 0);
    chk("reset_decided", int'(bus.decided_symbols), 0);

    // Min select: {5,3,9} picks state 1.
    beat(5, 3, 9, {M, M}, {M, P}, {P, M}, 0, 0, 1'b0, 1, 1, 3, {M, P}, -1, -1, 0);
    idle(); drain();
    chk("hold_out_valid_low", int'(bus.out_valid), 0);
    chk("hold_idx", int'(bus.best_state_idx), 1);
    chk("hold_energy", int'(bus.global_static_energy), 3);

    // Tie goes to index 0; second beat primes the 4-deep history.
    beat(4, 4, 4, {P, P}, {M, M}, {M, M}, 0, 0, 1'b0, 1, 0, 4, {P, P}, 2, 4, 1);
    idle(); drain();

    do_flush();
    chk("flush_primed", int'(bus.history_primed), 0);
    chk("flush_idx", int'(bus.best_state_idx), 0);
    chk("flush_static0", int'(bus.precomputed_static_val[0]), 0);

    // Back-to-back {+1,+1} then {-1,-1}, then an rse-biased beat.
    beat(9, 8, 1, {M, M}, {M, M}, {P, P}, 0, 0, 1'b0, 1, 2, 1, {P, P}, 3, 5, 0);
    beat(2, 7, 7, {M, M}, {P, P}, {P, P}, 0, 0, 1'b0, 1, 0, 2, {M, M}, 4, 4, 1);
    beat(1, 2, 3, {M, P}, {M, M}, {M, M}, 3, -5, 1'b0, 1, 0, 1, {M, P}, -5, -15, 1);
    idle(); drain();

    // Flush one cycle after in_valid, then in_valid together with flush: both dropped.
    beat(5, 3, 9, {M, M}, {M, P}, {P, M}, 0, 0, 1'b0, 0, 0, 0, 4'b0, 0, 0, 0);
    do_flush(); drain();
    chk("midflush_primed", int'(bus.history_primed), 0);
    beat(5, 3, 9, {M, M}, {M, P}, {P, M}, 0, 0, 1'b1, 0, 0, 0, 4'b0, 0, 0, 0);
    idle(); drain();
    beat(5, 3, 9, {M, M}, {M, P}, {P, M}, 0, 0, 1'b0, 1, 1, 3, {M, P}, -1, -1, 0);
    idle(); drain();

    // Saturation both ways with taps of 127.
    set_taps(0, 127);
    do_flush();
    beat(1, 2, 3, {P, P}, {M, M}, {M, M}, 100, 100, 1'b0, 1, 0, 1, {P, P}, 127, 127, 0);
    beat(1, 2, 3, {M, M}, {P, P}, {P, P}, -100, -100, 1'b0, 1, 0, 1, {M, M}, -100, -100, 1);
    beat(1, 2, 3, {M, M}, {P, P}, {P, P}, -100, -100, 1'b0, 1, 0, 1, {M, M}, -128, -128, 1);
    idle(); drain();

    // Eight continuous beats.
    set_taps(1, 0);
    do_flush();
    for (int i = 0; i < 8; i++) begin
      beat((i % 3 == 0) ? i + 1 : 20, (i % 3 == 1) ? i + 1 : 20, (i % 3 == 2) ? i + 1 : 20,
           {P, P}, {P, P}, {P, P}, 0, 0, 1'b0, 1,
           i % 3, i + 1, {P, P}, (i == 0) ? 3 : 10, (i == 0) ? 5 : 14, (i == 0) ? 0 : 1);
    end
    idle(); drain(); drain();

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
